// File: rtl/outbox_tx_pkg.sv
// -----------------------------------------------------------------------------
// outbox_tx_pkg
//
// Purpose:
//   Shared definitions for the outbox UART transmitter: the FSM state
//   encoding, the default baud divider and the frame geometry constants.
//   Both the transmitter top and its baud counter import this package so
//   the divider default and the state encoding live in one place.
//
// Contents:
//   BAUD_DIV_DEFAULT  default clock cycles per UART bit
//   DATA_BITS         payload bits per 8N1 frame
//   tx_state_t        six-state transmitter FSM encoding
//   baud_hold()       states in which the baud counter is held at zero
// -----------------------------------------------------------------------------
package outbox_tx_pkg;

    // Default clock cycles per UART bit (e.g. 10 MHz / 104 ~ 96 kbaud).
    localparam int BAUD_DIV_DEFAULT = 104;

    // Payload bits in one 8N1 frame.
    localparam int DATA_BITS = 8;

    // Transmitter FSM states. IDLE is all-zero so a cleared state register
    // always lands in a safe, non-transmitting state.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } tx_state_t;

    // The baud counter only runs while a bit is on the line. Holding it at
    // zero through IDLE, READ and LOAD guarantees the start bit always gets
    // a full bit period, no matter how long the block sat idle.
    function automatic logic baud_hold(input tx_state_t state);
        return (state == ST_IDLE) || (state == ST_READ) || (state == ST_LOAD);
    endfunction

endpackage

// File: rtl/outbox_tx_baud_tick.sv
// -----------------------------------------------------------------------------
// baud_tick
//
// Purpose:
//   Bit-period timer for the outbox transmitter. Counts 0..BAUD_DIV-1 and
//   raises tick during the last cycle of each bit period, so the FSM can
//   advance on the same edge that the counter wraps back to zero.
//
// Parameters:
//   BAUD_DIV  clock cycles per UART bit, 2..65535
//
// Ports:
//   clk    in   system clock, rising edge
//   i_rst  in   synchronous active-high reset, clears the counter
//   clr    in   hold the counter at zero (used outside of bit periods)
//   tick   out  1 in the final cycle of a bit period
// -----------------------------------------------------------------------------
module baud_tick
    import outbox_tx_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic clk,
    input  logic i_rst,
    input  logic clr,
    output logic tick
);

    // Counter is exactly $clog2(BAUD_DIV) bits; BAUD_DIV >= 2 keeps this >= 1.
    localparam int               CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] count;

    // Free-running modulo-BAUD_DIV counter. clr has the same effect as reset
    // so the FSM can restart bit timing without touching anything else.
    always_ff @(posedge clk) begin
        if (i_rst || clr) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // Decoded from the registered count only, so tick is glitch-free with
    // respect to any block input.
    assign tick = (count == CNT_LAST);

endmodule

// File: rtl/outbox_tx.sv
// -----------------------------------------------------------------------------
// outbox_tx
//
// Purpose:
//   Drains bytes from the outbox FIFO and sends each one as an 8N1 UART
//   frame, LSB first. One byte is popped per frame; the FIFO status is only
//   looked at while idle, so the line timing never depends on what the FIFO
//   does mid-frame.
//
//   Cycle sequence per byte (B = BAUD_DIV):
//     IDLE  (1+)  wait for empty=0
//     READ  (1)   rd=1, pops the FIFO head
//     LOAD  (1)   FIFO data is valid now, capture into the shift register
//     START (B)   tx=0
//     DATA  (8*B) tx = shift register bit 0, shift right per bit
//     STOP  (B)   tx=1
//
// Parameters:
//   BAUD_DIV  clock cycles per UART bit, 2..65535
//
// Ports:
//   clk    in   system clock, rising edge
//   i_rst  in   synchronous active-high reset
//   empty  in   FIFO empty flag, 1 = nothing to send
//   data   in   FIFO head byte, valid the cycle after an rd pulse
//   rd     out  one-cycle FIFO pop strobe
//   tx     out  UART line, idle high
//   busy   out  1 whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module outbox_tx
    import outbox_tx_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic       empty,
    input  logic [7:0] data,
    output logic       rd,
    output logic       tx,
    output logic       busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t  state;
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
    logic       baud_clr;
    logic       baud_done;

    // Bit timing runs only while a bit is on the line.
    assign baud_clr = baud_hold(state);

    baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick (
        .clk   (clk),
        .i_rst (i_rst),
        .clr   (baud_clr),
        .tick  (baud_done)
    );

    // Transmitter FSM with registered outputs. Every output is assigned on
    // the edge that enters the state it belongs to, so rd, tx and busy are
    // plain flops and nothing from empty or data reaches tx combinationally.
    // Reset drops any frame in flight; a byte already popped is not resent.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            rd        <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            rd <= 1'b0;

            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (!empty) begin
                        state <= ST_READ;
                        rd    <= 1'b1;
                        busy  <= 1'b1;
                    end
                end

                ST_READ: begin
                    state <= ST_LOAD;
                end

                // The FIFO presents the popped byte one cycle after rd, so
                // it is captured here rather than in READ.
                ST_LOAD: begin
                    shift_reg <= data;
                    bit_cnt   <= '0;
                    tx        <= 1'b0;
                    state     <= ST_START;
                end

                ST_START: begin
                    if (baud_done) begin
                        tx    <= shift_reg[0];
                        state <= ST_DATA;
                    end
                end

                // At each bit boundary the next bit (shift_reg[1], which is
                // about to become bit 0) goes straight onto the line. After
                // the eighth bit the counter wraps from 7 and the line goes
                // high for the stop bit instead.
                ST_DATA: begin
                    if (baud_done) begin
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == LAST_BIT) begin
                            tx    <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            tx <= shift_reg[1];
                        end
                    end
                end

                ST_STOP: begin
                    if (baud_done) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_outbox_tx.sv
// -----------------------------------------------------------------------------
// tb_outbox_tx
//
// Purpose:
//   Self-checking bench for outbox_tx with BAUD_DIV=4. A FIFO model feeds
//   bytes; each byte queued also pushes its expected frame into a scoreboard.
//   A separate monitor watches the line, pops the scoreboard at every start
//   bit and compares the whole frame cycle by cycle.
// -----------------------------------------------------------------------------
module tb_outbox_tx;

    localparam int BAUD  = 4;
    localparam int FRAME = 10 * BAUD;

    typedef struct {
        logic [7:0] data;
        bit         aborted;
        int         gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       empty;
    logic [7:0] data;
    logic       rd;
    logic       tx;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int cyc         = 0;
    int rd_count    = 0;
    int rd_cyc      = -100;
    int frames_done = 0;
    int mon_cnt     = 0;
    bit mon_in_frame = 1'b0;
    bit toggle_mode  = 1'b0;

    logic [7:0] fifo_q[$];
    exp_t       exp_q[$];
    int         start_at[$];
    int         end_at[$];

    outbox_tx #(
        .BAUD_DIV (BAUD)
    ) dut (
        .clk   (clk),
        .i_rst (i_rst),
        .empty (empty),
        .data  (data),
        .rd    (rd),
        .tx    (tx),
        .busy  (busy)
    );

    // 10-unit clock period.
    initial forever #5 clk = ~clk;

    // One comparison: counts it and reports a miss.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Queue a byte in the FIFO model and its expected frame in the scoreboard.
    task automatic applyStimulus(input logic [7:0] b, input bit aborted, input int gap);
        exp_t e;
        e.data    = b;
        e.aborted = aborted;
        e.gap     = gap;
        fifo_q.push_back(b);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitFrames(input int target, input int budget);
        int k;
        k = 0;
        while (frames_done < target && k < budget) begin
            tick();
            k++;
        end
        checkOutput("frames_in_time", 32'(frames_done), 32'(target));
        repeat (2) tick();
    endtask

    // FIFO model: pop on rd, present data the next cycle. In toggle mode the
    // flag and data wiggle every cycle to show they are ignored mid-frame.
    initial begin
        bit rd_seen;
        data  = 8'h00;
        empty = 1'b1;
        forever begin
            @(negedge clk);
            rd_seen = (rd === 1'b1);
            @(posedge clk);
            #2;
            if (rd_seen) begin
                if (fifo_q.size() > 0) data = fifo_q.pop_front();
            end else if (toggle_mode) begin
                data = 8'($urandom);
            end
            if (toggle_mode) empty = ~empty;
            else             empty = (fifo_q.size() == 0);
        end
    end

    // Monitor: samples on the falling edge, checks rd pulse shape, frame bit
    // timing against the scoreboard, inter-frame gap and busy after STOP.
    initial begin
        exp_t       cur;
        int         frame_err;
        int         gap_cnt;
        int         p;
        logic [7:0] rx_byte;
        logic       exp_bit;
        bit         check_idle;
        bit         rd_prev;
        cur.data = 8'h00; cur.aborted = 1'b0; cur.gap = -1;
        frame_err = 0; gap_cnt = 0; p = 0; rx_byte = 8'h00; exp_bit = 1'b1;
        check_idle = 1'b0; rd_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rd === 1'b1) begin
                checkOutput("rd_pulse_width", 32'(rd_prev), 32'd0);
                rd_count++;
                rd_cyc = cyc;
            end
            rd_prev = (rd === 1'b1);
            if (i_rst !== 1'b0) begin
                if (mon_in_frame) begin
                    checkOutput("abort_expected", 32'(cur.aborted), 32'd1);
                    mon_in_frame = 1'b0;
                end
                check_idle = 1'b0;
                gap_cnt    = 0;
            end else begin
                if (!mon_in_frame && check_idle) begin
                    checkOutput("busy_after_stop", 32'(busy), 32'd0);
                    checkOutput("tx_after_stop", 32'(tx), 32'd1);
                    check_idle = 1'b0;
                end
                if (!mon_in_frame && tx === 1'b0) begin
                    checkOutput("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) cur = exp_q.pop_front();
                    checkOutput("rd_to_start", 32'(cyc - rd_cyc), 32'd2);
                    if (cur.gap >= 0) checkOutput("gap_high_cycles", 32'(gap_cnt), 32'(cur.gap));
                    start_at.push_back(cyc);
                    mon_in_frame = 1'b1;
                    mon_cnt      = 0;
                    frame_err    = 0;
                    rx_byte      = 8'h00;
                end else if (!mon_in_frame) begin
                    gap_cnt++;
                end
                if (mon_in_frame) begin
                    p = mon_cnt / BAUD;
                    if (p == 0)      exp_bit = 1'b0;
                    else if (p == 9) exp_bit = 1'b1;
                    else             exp_bit = cur.data[p-1];
                    if (tx !== exp_bit || busy !== 1'b1) frame_err++;
                    if (p >= 1 && p <= 8 && (mon_cnt % BAUD) == BAUD / 2) rx_byte[p-1] = tx;
                    mon_cnt++;
                    if (mon_cnt == FRAME) begin
                        checkOutput("frame_timing", 32'(frame_err), 32'd0);
                        checkOutput("frame_data", 32'(rx_byte), 32'(cur.data));
                        checkOutput("frame_not_aborted", 32'(cur.aborted), 32'd0);
                        end_at.push_back(cyc);
                        frames_done++;
                        mon_in_frame = 1'b0;
                        check_idle   = 1'b1;
                        gap_cnt      = 0;
                    end
                end
            end
        end
    end

    // Directed sequence.
    initial begin
        int base_rd;
        int base_frames;
        int base_starts;
        int base_ends;
        int k;
        i_rst = 1'b1;

        $display("[TB] reset held 3 cycles");
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("reset_tx", 32'(tx), 32'd1);
            checkOutput("reset_rd", 32'(rd), 32'd0);
            checkOutput("reset_busy", 32'(busy), 32'd0);
        end
        i_rst = 1'b0;
        repeat (100) tick();
        checkOutput("idle_no_rd", 32'(rd_count), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_tx", 32'(tx), 32'd1);

        $display("[TB] single byte 0xA5");
        base_rd = rd_count;
        applyStimulus(8'hA5, 1'b0, -1);
        waitFrames(1, 200);
        checkOutput("a5_rd_pulses", 32'(rd_count - base_rd), 32'd1);

        $display("[TB] back-to-back 0x00, 0xFF");
        base_rd     = rd_count;
        base_frames = frames_done;
        base_starts = start_at.size();
        base_ends   = end_at.size();
        applyStimulus(8'h00, 1'b0, -1);
        applyStimulus(8'hFF, 1'b0, 3);
        waitFrames(base_frames + 2, 300);
        checkOutput("b2b_rd_pulses", 32'(rd_count - base_rd), 32'd2);
        if (end_at.size() >= base_ends + 2 && start_at.size() >= base_starts + 1)
            checkOutput("b2b_span", 32'(end_at[base_ends + 1] + 1 - start_at[base_starts]), 32'd83);
        else
            checkOutput("b2b_span_frames", 32'(end_at.size()), 32'(base_ends + 2));

        $display("[TB] reset during data bit 3 of 0x5A");
        base_rd     = rd_count;
        base_frames = frames_done;
        applyStimulus(8'h5A, 1'b1, -1);
        applyStimulus(8'h3C, 1'b0, -1);
        k = 0;
        while (!(mon_in_frame && mon_cnt >= 17) && k < 300) begin
            tick();
            k++;
        end
        checkOutput("abort_point_reached", 32'(mon_in_frame && mon_cnt >= 17), 32'd1);
        i_rst = 1'b1;
        tick();
        checkOutput("abort_tx", 32'(tx), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_rd", 32'(rd), 32'd0);
        i_rst = 1'b0;
        tick();
        checkOutput("post_reset_rd", 32'(rd), 32'd1);
        waitFrames(base_frames + 1, 200);
        checkOutput("abort_rd_pulses", 32'(rd_count - base_rd), 32'd2);

        $display("[TB] empty/data toggling during 0xC3");
        base_rd     = rd_count;
        base_frames = frames_done;
        applyStimulus(8'hC3, 1'b0, -1);
        k = 0;
        while (rd_count == base_rd && k < 50) begin
            tick();
            k++;
        end
        checkOutput("toggle_rd_seen", 32'(rd_count - base_rd), 32'd1);
        toggle_mode = 1'b1;
        repeat (30) tick();
        toggle_mode = 1'b0;
        checkOutput("toggle_no_extra_rd", 32'(rd_count - base_rd), 32'd1);
        waitFrames(base_frames + 1, 200);
        checkOutput("toggle_rd_total", 32'(rd_count - base_rd), 32'd1);

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("fifo_drained", 32'(fifo_q.size()), 32'd0);
        checkOutput("total_frames", 32'(frames_done), 32'd5);
        checkOutput("total_rd", 32'(rd_count), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
